// File: rtl/nfc_atom_ca_sequencer.sv
// Atomic command/address sequencer (ACG slot 3): drives SDR NAND CEn/CLE/ALE/WEn/DQ with programmable timing.
// Optional build macro NFC_CA_SEQ_STATS_EN adds the oByteCount WEn-rise counter output.
module nfc_atom_ca_sequencer #(
    parameter int NumberOfWays = 4,
    parameter int P_tCALS      = 2,
    parameter int P_tWP        = 2,
    parameter int P_tWH        = 2,
    parameter int P_tCALH      = 2
) (
    input  logic                    iSystemClock,
    input  logic                    iReset,
    input  logic                    iStart,
    input  logic [NumberOfWays-1:0] iTargetWay,
    input  logic                    iCASelect,
    input  logic [39:0]             iCAData,
    input  logic [2:0]              iNumOfData,
    output logic                    oReady,
    output logic                    oLastStep,
`ifdef NFC_CA_SEQ_STATS_EN
    output logic [15:0]             oByteCount,
`endif
    output logic [NumberOfWays-1:0] oPO_CEn,
    output logic                    oPO_CLE,
    output logic                    oPO_ALE,
    output logic                    oPO_WEn,
    output logic [7:0]              oPO_DQ,
    output logic                    oPO_DQOE
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_WELOW,
        S_WEHIGH,
        S_HOLD,
        S_DONE
    } state_t;

    localparam int TW = 8;
    localparam logic [TW-1:0] LD_CALS = TW'(P_tCALS - 1);
    localparam logic [TW-1:0] LD_WP   = TW'(P_tWP - 1);
    localparam logic [TW-1:0] LD_WH   = TW'(P_tWH - 1);
    localparam logic [TW-1:0] LD_CALH = TW'(P_tCALH - 1);

    state_t                  r_state;
    state_t                  w_nextState;
    logic [TW-1:0]           r_timer;
    logic [TW-1:0]           w_nextTimer;
    logic                    w_accept;
    logic                    w_timerDone;
    logic                    w_byteDone;
    logic                    w_lastByte;
    logic                    w_busyPins;
    logic [2:0]              w_byteCount;

    logic [NumberOfWays-1:0] r_wayN;
    logic                    r_caSelect;
    logic [7:0]              r_dq;
    logic [31:0]             r_pending;
    logic [2:0]              r_bytesLeft;

    assign w_accept    = iStart && (r_state == S_IDLE);
    assign w_timerDone = (r_timer == '0);
    assign w_byteDone  = (r_state == S_WEHIGH) && w_timerDone;
    assign w_lastByte  = (r_bytesLeft == 3'd1);

    // Address bursts are clamped to the five bytes that iCAData can hold.
    always_comb begin
        w_byteCount = 3'd1;
        if (!iCASelect) begin
            if (iNumOfData >= 3'd4)
                w_byteCount = 3'd5;
            else
                w_byteCount = iNumOfData + 3'd1;
        end
    end

    always_ff @(posedge iSystemClock) begin
        if (iReset) begin
            r_state <= S_IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_nextState;
            r_timer <= w_nextTimer;
        end
    end

    // Single down-counter: reloaded on each state entry, state moves on when it hits zero.
    always_comb begin
        w_nextState = r_state;
        w_nextTimer = w_timerDone ? r_timer : r_timer - 1'b1;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_nextState = S_SETUP;
                    w_nextTimer = LD_CALS;
                end
            end
            S_SETUP: begin
                if (w_timerDone) begin
                    w_nextState = S_WELOW;
                    w_nextTimer = LD_WP;
                end
            end
            S_WELOW: begin
                if (w_timerDone) begin
                    w_nextState = S_WEHIGH;
                    w_nextTimer = LD_WH;
                end
            end
            S_WEHIGH: begin
                if (w_timerDone) begin
                    if (w_lastByte) begin
                        w_nextState = S_HOLD;
                        w_nextTimer = LD_CALH;
                    end else begin
                        w_nextState = S_WELOW;
                        w_nextTimer = LD_WP;
                    end
                end
            end
            S_HOLD: begin
                if (w_timerDone) begin
                    w_nextState = S_DONE;
                    w_nextTimer = '0;
                end
            end
            S_DONE: begin
                w_nextState = S_IDLE;
                w_nextTimer = '0;
            end
            default: begin
                w_nextState = S_IDLE;
                w_nextTimer = '0;
            end
        endcase
    end

    // Next byte is loaded only after WEn has risen, so DQ never moves during a low pulse.
    always_ff @(posedge iSystemClock) begin
        if (iReset) begin
            r_wayN      <= '1;
            r_caSelect  <= 1'b0;
            r_dq        <= 8'h00;
            r_pending   <= '0;
            r_bytesLeft <= '0;
        end else if (w_accept) begin
            r_wayN      <= iTargetWay;
            r_caSelect  <= iCASelect;
            r_dq        <= iCAData[39:32];
            r_pending   <= iCAData[31:0];
            r_bytesLeft <= w_byteCount;
        end else if (w_byteDone) begin
            r_bytesLeft <= r_bytesLeft - 3'd1;
            if (!w_lastByte) begin
                r_dq      <= r_pending[31:24];
                r_pending <= {r_pending[23:0], 8'h00};
            end
        end
    end

    // CEn follows the last accepted way even when idle to avoid CE glitches between ops.
    always_comb begin
        w_busyPins = (r_state == S_SETUP) || (r_state == S_WELOW) ||
                     (r_state == S_WEHIGH) || (r_state == S_HOLD);
        oReady     = (r_state == S_IDLE);
        oLastStep  = (r_state == S_DONE);
        oPO_CEn    = r_wayN;
        oPO_CLE    = w_busyPins && r_caSelect;
        oPO_ALE    = w_busyPins && !r_caSelect;
        oPO_WEn    = (r_state != S_WELOW);
        oPO_DQOE   = w_busyPins;
        oPO_DQ     = w_busyPins ? r_dq : 8'h00;
    end

`ifdef NFC_CA_SEQ_STATS_EN
    logic [15:0] r_byteCount;

    // Counts WEn rising edges, i.e. bytes actually latched by the NAND.
    always_ff @(posedge iSystemClock) begin
        if (iReset)
            r_byteCount <= 16'h0000;
        else if ((r_state == S_WELOW) && w_timerDone)
            r_byteCount <= r_byteCount + 16'h0001;
    end

    assign oByteCount = r_byteCount;
`endif

endmodule

// File: tb/tb_nfc_atom_ca_sequencer.sv
// Directed-vector bench for nfc_atom_ca_sequencer: table of ops plus hand-written reset/held-start sequences.
// Optional build macro NFC_CA_SEQ_STATS_EN also checks the oByteCount output.
module tb_nfc_atom_ca_sequencer;

    typedef struct {
        logic        caSel;
        logic [3:0]  way;
        logic [39:0] data;
        logic [2:0]  numOfData;
        logic        busyPulse;
        int          expPulses;
        logic [39:0] expBytes;
        int          expLatency;
    } vec_t;

    logic        iSystemClock;
    logic        iReset;
    logic        iStart;
    logic [3:0]  iTargetWay;
    logic        iCASelect;
    logic [39:0] iCAData;
    logic [2:0]  iNumOfData;
    logic        oReady;
    logic        oLastStep;
    logic [3:0]  oPO_CEn;
    logic        oPO_CLE;
    logic        oPO_ALE;
    logic        oPO_WEn;
    logic [7:0]  oPO_DQ;
    logic        oPO_DQOE;
`ifdef NFC_CA_SEQ_STATS_EN
    logic [15:0] oByteCount;
`endif

    int testsRun;
    int testsFailed;

    nfc_atom_ca_sequencer dut (
        .iSystemClock (iSystemClock),
        .iReset       (iReset),
        .iStart       (iStart),
        .iTargetWay   (iTargetWay),
        .iCASelect    (iCASelect),
        .iCAData      (iCAData),
        .iNumOfData   (iNumOfData),
        .oReady       (oReady),
        .oLastStep    (oLastStep),
`ifdef NFC_CA_SEQ_STATS_EN
        .oByteCount   (oByteCount),
`endif
        .oPO_CEn      (oPO_CEn),
        .oPO_CLE      (oPO_CLE),
        .oPO_ALE      (oPO_ALE),
        .oPO_WEn      (oPO_WEn),
        .oPO_DQ       (oPO_DQ),
        .oPO_DQOE     (oPO_DQOE)
    );

    initial begin
        iSystemClock = 1'b0;
        forever #5 iSystemClock = ~iSystemClock;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyReset();
        iReset = 1'b1;
        repeat (2) @(posedge iSystemClock);
        @(negedge iSystemClock);
        iReset = 1'b0;
    endtask

    // Runs one op; latency counts clock edges with the accept edge as edge 1.
    task automatic applyStimulus(input vec_t v, input string tag);
        int          edges;
        int          pulses;
        int          latency;
        logic        prevWEn;
        logic        ctlBad;
        logic        dqBad;
        logic [7:0]  curByte;
        logic [39:0] captured;
        edges    = 0;
        pulses   = 0;
        latency  = 0;
        prevWEn  = 1'b1;
        ctlBad   = 1'b0;
        dqBad    = 1'b0;
        curByte  = 8'h00;
        captured = '0;
        @(negedge iSystemClock);
        iStart     = 1'b1;
        iTargetWay = v.way;
        iCASelect  = v.caSel;
        iCAData    = v.data;
        iNumOfData = v.numOfData;
        @(posedge iSystemClock);
        edges = 1;
        @(negedge iSystemClock);
        iStart = 1'b0;
        checkOutput({tag, " readyDrop"}, {63'd0, oReady}, 64'd0);
        while (latency == 0 && edges < 200) begin
            if (!oPO_WEn) begin
                if (prevWEn) begin
                    pulses++;
                    curByte  = oPO_DQ;
                    captured = {captured[31:0], oPO_DQ};
                end else if (oPO_DQ !== curByte) begin
                    dqBad = 1'b1;
                end
                if (oPO_CLE !== v.caSel || oPO_ALE !== !v.caSel || oPO_CEn !== v.way || oPO_DQOE !== 1'b1)
                    ctlBad = 1'b1;
            end
            prevWEn = oPO_WEn;
            if (oLastStep) begin
                latency = edges;
                if (oPO_CLE || oPO_ALE || oPO_DQOE)
                    ctlBad = 1'b1;
            end else begin
                if (v.busyPulse) begin
                    iStart     = (edges == 4);
                    iCASelect  = 1'b1;
                    iCAData    = 40'hFF_FFFF_FFFF;
                    iTargetWay = 4'b0000;
                end
                @(posedge iSystemClock);
                edges++;
                @(negedge iSystemClock);
            end
        end
        iStart = 1'b0;
        checkOutput({tag, " latency"}, 64'(latency), 64'(v.expLatency));
        checkOutput({tag, " pulses"}, 64'(pulses), 64'(v.expPulses));
        checkOutput({tag, " bytes"}, {24'd0, captured}, {24'd0, v.expBytes});
        checkOutput({tag, " pinsDuringOp"}, {63'd0, ctlBad}, 64'd0);
        checkOutput({tag, " dqStable"}, {63'd0, dqBad}, 64'd0);
        @(posedge iSystemClock);
        @(negedge iSystemClock);
        checkOutput({tag, " idleReady"}, {62'd0, oReady, oLastStep}, 64'b10);
        checkOutput({tag, " idleCEnHeld"}, {60'd0, oPO_CEn}, {60'd0, v.way});
    endtask

    vec_t vecs[7];

    initial begin
        int edges;
        int seen;
        int pulses;
        logic prevWEn;
        vec_t stats0;
        vec_t stats1;

        testsRun    = 0;
        testsFailed = 0;
        iReset      = 1'b0;
        iStart      = 1'b0;
        iTargetWay  = 4'b1111;
        iCASelect   = 1'b0;
        iCAData     = '0;
        iNumOfData  = '0;

        vecs[0] = '{1'b1, 4'b1110, 40'hEE_0000_0000, 3'd0, 1'b0, 1, 40'h00_0000_00EE, 9};
        vecs[1] = '{1'b0, 4'b1110, 40'h01_0000_0000, 3'd0, 1'b0, 1, 40'h00_0000_0001, 9};
        vecs[2] = '{1'b0, 4'b1110, 40'h01_0203_0405, 3'd4, 1'b0, 5, 40'h01_0203_0405, 25};
        vecs[3] = '{1'b0, 4'b0111, 40'h0A_0B0C_0D0E, 3'd7, 1'b0, 5, 40'h0A_0B0C_0D0E, 25};
        vecs[4] = '{1'b0, 4'b1101, 40'h11_2233_4455, 3'd2, 1'b1, 3, 40'h00_0011_2233, 17};
        vecs[5] = '{1'b1, 4'b1011, 40'h70_1234_5678, 3'd5, 1'b0, 1, 40'h00_0000_0070, 9};
        vecs[6] = '{1'b1, 4'b1111, 40'hFF_0000_0000, 3'd0, 1'b0, 1, 40'h00_0000_00FF, 9};

        applyReset();
        checkOutput("reset ready/last", {62'd0, oReady, oLastStep}, 64'b10);
        checkOutput("reset CEn", {60'd0, oPO_CEn}, 64'hF);
        checkOutput("reset CLE/ALE/WEn/DQOE", {60'd0, oPO_CLE, oPO_ALE, oPO_WEn, oPO_DQOE}, 64'b0010);
        checkOutput("reset DQ", {56'd0, oPO_DQ}, 64'h00);

        for (int i = 0; i < 7; i++)
            applyStimulus(vecs[i], $sformatf("vec%0d", i));

        // Reset asserted once the third address byte is on the bus.
        @(negedge iSystemClock);
        iStart     = 1'b1;
        iTargetWay = 4'b1110;
        iCASelect  = 1'b0;
        iCAData    = 40'h01_0203_0405;
        iNumOfData = 3'd4;
        @(posedge iSystemClock);
        @(negedge iSystemClock);
        iStart  = 1'b0;
        edges   = 0;
        pulses  = 0;
        prevWEn = 1'b1;
        while (pulses < 3 && edges < 100) begin
            if (!oPO_WEn && prevWEn)
                pulses++;
            prevWEn = oPO_WEn;
            if (pulses < 3) begin
                @(posedge iSystemClock);
                edges++;
                @(negedge iSystemClock);
            end
        end
        checkOutput("midReset reached byte3", {56'd0, oPO_DQ}, 64'h03);
        iReset = 1'b1;
        @(posedge iSystemClock);
        @(negedge iSystemClock);
        checkOutput("midReset CEn", {60'd0, oPO_CEn}, 64'hF);
        checkOutput("midReset WEn/ALE/DQOE", {61'd0, oPO_WEn, oPO_ALE, oPO_DQOE}, 64'b100);
        checkOutput("midReset ready/last", {62'd0, oReady, oLastStep}, 64'b10);
        iReset = 1'b0;
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge iSystemClock);
            if (oLastStep)
                seen++;
        end
        checkOutput("midReset noLastStep", 64'(seen), 64'd0);

        // Held-high iStart after DONE immediately launches a second op.
        @(negedge iSystemClock);
        iStart     = 1'b1;
        iTargetWay = 4'b1110;
        iCASelect  = 1'b1;
        iCAData    = 40'h90_0000_0000;
        iNumOfData = 3'd0;
        edges      = 0;
        seen       = 0;
        while (seen == 0 && edges < 100) begin
            @(posedge iSystemClock);
            edges++;
            @(negedge iSystemClock);
            if (oLastStep)
                seen = edges;
        end
        checkOutput("heldStart firstLatency", 64'(seen), 64'd9);
        @(posedge iSystemClock);
        @(negedge iSystemClock);
        checkOutput("heldStart idleCycle", {63'd0, oReady}, 64'd1);
        @(posedge iSystemClock);
        @(negedge iSystemClock);
        checkOutput("heldStart relaunch", {62'd0, oReady, oPO_CLE}, 64'b01);
        iStart = 1'b0;
        edges  = 1;
        seen   = 0;
        while (seen == 0 && edges < 100) begin
            @(posedge iSystemClock);
            edges++;
            @(negedge iSystemClock);
            if (oLastStep)
                seen = edges;
        end
        checkOutput("heldStart secondLatency", 64'(seen), 64'd9);

`ifdef NFC_CA_SEQ_STATS_EN
        applyReset();
        checkOutput("stats reset", {48'd0, oByteCount}, 64'd0);
        stats0 = vecs[0];
        stats1 = vecs[2];
        applyStimulus(stats0, "stats cmd");
        applyStimulus(stats1, "stats addr");
        checkOutput("stats byteCount", {48'd0, oByteCount}, 64'd6);
`else
        stats0 = vecs[0];
        stats1 = stats0;
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
